sipo_rx: RTL and testbench

//  Serial-in/parallel-out deserializer: receive end of the shift-register serial link.

---
 rtl/sipo_rx.sv | 69 ++++++
 tb/tb_sipo_rx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: assembles WIDTH serial bits into a word and hands it
// off through a valid/ready holding register, flagging words lost to backpressure.
module sipo_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     s_in,
    input  logic                     s_valid,
    output logic [WIDTH-1:0]         p_out,
    output logic                     p_valid,
    input  logic                     p_ready,
    output logic                     overrun,
    output logic [$clog2(WIDTH)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] cand;
    logic             done;
    logic             take;

    // cand is the shift register as it will look after absorbing s_in this edge
    always_comb begin
        cand = sr;
        if (MSB_FIRST) begin
            cand = {sr[WIDTH-2:0], s_in};
        end else begin
            cand = {s_in, sr[WIDTH-1:1]};
        end
        done = s_valid && (bit_cnt == LAST_BIT);
        take = p_valid && p_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr      <= '0;
            bit_cnt <= '0;
            p_out   <= '0;
            p_valid <= 1'b0;
            overrun <= 1'b0;
        end else if (clr) begin
            sr      <= '0;
            bit_cnt <= '0;
            p_out   <= '0;
            p_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (s_valid) begin
                sr      <= cand;
                bit_cnt <= done ? '0 : bit_cnt + 1'b1;
            end
            // A word finishing while the previous one is still unread is dropped
            if (done && (!p_valid || take)) begin
                p_out   <= cand;
                p_valid <= 1'b1;
            end else if (done) begin
                overrun <= 1'b1;
            end else if (take) begin
                p_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: one MSB-first and one LSB-first instance share stimulus;
// expected words are queued when driven and popped when the receiver presents them.
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr = 1'b0;
    logic       s_in = 1'b0;
    logic       s_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic [3:0] p_out_m, p_out_l;
    logic       p_valid_m, p_valid_l;
    logic       overrun_m, overrun_l;
    logic [1:0] bit_cnt_m, bit_cnt_l;

    int checks = 0;
    int errors = 0;

    logic [3:0] q_m[$];
    logic [3:0] q_l[$];
    logic [3:0] held_m = 4'b0;
    logic [3:0] held_l = 4'b0;

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .clr(clr), .s_in(s_in), .s_valid(s_valid),
        .p_out(p_out_m), .p_valid(p_valid_m), .p_ready(p_ready),
        .overrun(overrun_m), .bit_cnt(bit_cnt_m)
    );

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .clr(clr), .s_in(s_in), .s_valid(s_valid),
        .p_out(p_out_l), .p_valid(p_valid_l), .p_ready(p_ready),
        .overrun(overrun_l), .bit_cnt(bit_cnt_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pout_m"}, 32'(p_out_m), 32'h0);
        chk({tag, "_pout_l"}, 32'(p_out_l), 32'h0);
        chk({tag, "_pvalid"}, 32'({p_valid_m, p_valid_l}), 32'h0);
        chk({tag, "_overrun"}, 32'({overrun_m, overrun_l}), 32'h0);
        chk({tag, "_bitcnt_m"}, 32'(bit_cnt_m), 32'h0);
        chk({tag, "_bitcnt_l"}, 32'(bit_cnt_l), 32'h0);
    endtask

    // bits[3] is sent first; gapped inserts i idle cycles before bit i
    task automatic send_word(input string tag, input logic [3:0] bits, input bit gapped,
                             input logic rdy_last, input bit accept);
        logic [3:0] lsb_word;
        logic [1:0] cnt_before;
        for (int k = 0; k < 4; k++) lsb_word[k] = bits[3-k];
        for (int i = 0; i < 4; i++) begin
            cnt_before = bit_cnt_m;
            for (int g = 0; g < (gapped ? i : 0); g++) begin
                tick();
                chk({tag, "_gap_hold"}, 32'({bit_cnt_m, bit_cnt_l}), 32'({cnt_before, cnt_before}));
            end
            s_in    = bits[3-i];
            s_valid = 1'b1;
            p_ready = (i == 3) ? rdy_last : 1'b0;
            if (i == 3 && accept) begin
                q_m.push_back(bits);
                q_l.push_back(lsb_word);
            end
            tick();
            s_valid = 1'b0;
            p_ready = 1'b0;
            chk({tag, "_bitcnt"}, 32'({bit_cnt_m, bit_cnt_l}),
                32'({2'((i + 1) % 4), 2'((i + 1) % 4)}));
        end
        if (accept) begin
            if (q_m.size() == 0 || q_l.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_queue: observed empty expected entry", tag);
            end else begin
                held_m = q_m.pop_front();
                held_l = q_l.pop_front();
            end
            chk({tag, "_pvalid"}, 32'({p_valid_m, p_valid_l}), 32'h3);
        end else begin
            chk({tag, "_overrun"}, 32'({overrun_m, overrun_l}), 32'h3);
        end
        chk({tag, "_pout_m"}, 32'(p_out_m), 32'(held_m));
        chk({tag, "_pout_l"}, 32'(p_out_l), 32'(held_l));
    endtask

    task automatic take_word(input string tag);
        p_ready = 1'b1;
        tick();
        p_ready = 1'b0;
        chk({tag, "_taken"}, 32'({p_valid_m, p_valid_l}), 32'h0);
        chk({tag, "_pout_hold"}, 32'({p_out_m, p_out_l}), 32'({held_m, held_l}));
    endtask

    task automatic two_bits();
        for (int i = 0; i < 2; i++) begin
            s_in    = 1'b1;
            s_valid = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        chk("partial_cnt", 32'({bit_cnt_m, bit_cnt_l}), 32'({2'd2, 2'd2}));
    endtask

    initial begin
        // reset state
        #12;
        rst = 1'b1;
        tick();
        chk_idle("reset");
        tick();
        chk_idle("reset_idle");

        // consecutive bits, no consumer
        send_word("msb_word", 4'b1011, 1'b0, 1'b0, 1'b1);

        // ready with p_valid=1 and no completion frees the register
        take_word("take1");

        // gaps of 0..3 cycles between bits
        send_word("gap_word", 4'b1011, 1'b1, 1'b0, 1'b1);

        // second word while first unread -> dropped
        send_word("drop_word", 4'b0110, 1'b0, 1'b0, 1'b0);
        take_word("take2");
        chk("overrun_sticky", 32'({overrun_m, overrun_l}), 32'h3);

        // clear, then back-to-back words with ready on the completion edge
        clr = 1'b1;
        tick();
        clr = 1'b0;
        held_m = 4'b0;
        held_l = 4'b0;
        chk_idle("clr1");
        send_word("b2b_first", 4'b1011, 1'b0, 1'b0, 1'b1);
        send_word("b2b_second", 4'b0110, 1'b0, 1'b1, 1'b1);
        chk("b2b_no_overrun", 32'({overrun_m, overrun_l}), 32'h0);

        // async reset mid-word discards partial bits
        two_bits();
        rst = 1'b0;
        #2;
        held_m = 4'b0;
        held_l = 4'b0;
        chk_idle("async_rst");
        rst = 1'b1;
        send_word("post_rst", 4'b1100, 1'b0, 1'b0, 1'b1);

        // force overrun, then clr mid-word
        send_word("pre_clr_drop", 4'b0101, 1'b0, 1'b0, 1'b0);
        two_bits();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        held_m = 4'b0;
        held_l = 4'b0;
        chk_idle("clr2");
        send_word("post_clr", 4'b1100, 1'b0, 1'b0, 1'b1);
        chk("post_clr_overrun", 32'({overrun_m, overrun_l}), 32'h0);

        chk("queue_drained", 32'(q_m.size() + q_l.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
